// File: rtl/ddr_pkg.sv
// Shared constants and types for the chart playback and arrow logic.
// Lane order in a note: left, down, up, right (MSB to LSB).
package ddr_pkg;

  localparam int NOTE_W = 4;
  localparam logic [NOTE_W-1:0] END_CODE = 4'b1111;

  localparam int LANE_LEFT  = 3;
  localparam int LANE_DOWN  = 2;
  localparam int LANE_UP    = 1;
  localparam int LANE_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    WAIT
  } seq_state_e;

endpackage

// File: rtl/beat_timer.sv
// Free-running beat divider with enable and clear.
// tick_o marks the last enabled cycle of each BEAT_DIV-cycle period.
module beat_timer
  import ddr_pkg::*;
#(
  parameter int BEAT_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(BEAT_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEAT_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps the level chart ROM at the beat rate and turns each note
// into a one-cycle spawn pulse; reports done on END or exhaustion.
module note_sequencer
  import ddr_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int BEAT_DIV = 25000000,
  parameter int ROM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [NOTE_W-1:0] note,
  output logic [ADDR_W-1:0] addr,
  output logic [NOTE_W-1:0] spawn,
  output logic              spawn_valid,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W:0]   step
);

  localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

  seq_state_e        state_q;
  logic [LAT_W-1:0]  lat_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NOTE_W-1:0] spawn_q;
  logic              spawn_valid_q;
  logic              playing_q;
  logic              done_q;
  logic [ADDR_W:0]   step_q;

  logic tmr_en;
  logic tmr_clr;
  logic tick;

  // Beat keeps running through FETCH/EMIT so a fetch is never stretched.
  assign tmr_en  = (state_q == FETCH) || (state_q == EMIT) ||
                   ((state_q == WAIT) && !pause);
  assign tmr_clr = (state_q == IDLE);

  beat_timer #(
    .BEAT_DIV(BEAT_DIV)
  ) u_beat (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tmr_en),
    .clr_i (tmr_clr),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lat_q         <= '0;
      addr_q        <= '0;
      spawn_q       <= '0;
      spawn_valid_q <= 1'b0;
      playing_q     <= 1'b0;
      done_q        <= 1'b0;
      step_q        <= '0;
    end else begin
      spawn_q       <= '0;
      spawn_valid_q <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (start && !done_q) begin
            addr_q    <= '0;
            lat_q     <= '0;
            step_q    <= '0;
            playing_q <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          lat_q <= lat_q + LAT_W'(1);
          if (lat_q == LAT_LAST) begin
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (note == END_CODE) begin
            done_q    <= 1'b1;
            playing_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            step_q <= step_q + (ADDR_W+1)'(1);
            if (note != '0) begin
              spawn_q       <= note;
              spawn_valid_q <= 1'b1;
            end
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (tick) begin
            if (addr_q == '1) begin
              done_q    <= 1'b1;
              playing_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              addr_q  <= addr_q + ADDR_W'(1);
              lat_q   <= '0;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign addr        = addr_q;
  assign spawn       = spawn_q;
  assign spawn_valid = spawn_valid_q;
  assign playing     = playing_q;
  assign done        = done_q;
  assign step        = step_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed charts plus random charts/pauses,
// checked against an event-timeline model of chart playback.
module tb_note_sequencer;

  localparam int AW  = 6;
  localparam int DIV = 8;
  localparam int NP  = 2048;

  logic          clk;
  logic          rst;
  logic          start;
  logic          pause;
  logic [3:0]    note;
  logic [AW-1:0] addr;
  logic [3:0]    spawn;
  logic          spawn_valid;
  logic          playing;
  logic          done;
  logic [AW:0]   step;

  logic [3:0] rom [64];
  bit         pz  [NP];

  int vecs;
  int errs;

  int exp_sp_n[$];
  logic [3:0] exp_sp_m[$];
  int exp_e[$];
  int exp_done;
  int exp_step;
  int obs_n[$];
  logic [3:0] obs_m[$];

  note_sequencer #(
    .ADDR_W  (AW),
    .BEAT_DIV(DIV),
    .ROM_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .note       (note),
    .addr       (addr),
    .spawn      (spawn),
    .spawn_valid(spawn_valid),
    .playing    (playing),
    .done       (done),
    .step       (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) note <= rom[addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Playback timeline: addr changes at edge e, note emitted 2 edges later;
  // the beat counts every FETCH/EMIT cycle and every unpaused WAIT cycle.
  task automatic build_model();
    int e, st, j, cnt;
    exp_sp_n.delete();
    exp_sp_m.delete();
    exp_e.delete();
    e  = 1;
    st = 0;
    for (int k = 0; k < 64; k++) begin
      exp_e.push_back(e);
      if (rom[k] == 4'hF) begin
        exp_done = e + 2;
        exp_step = st;
        return;
      end
      st++;
      if (rom[k] != 4'h0) begin
        exp_sp_n.push_back(e + 2);
        exp_sp_m.push_back(rom[k]);
      end
      j   = e;
      cnt = 0;
      while (cnt < DIV && j < NP - 1) begin
        if (j < e + 2 || !pz[j]) cnt++;
        j++;
      end
      e = j;
    end
    exp_done = e;
    exp_step = st;
  endtask

  function automatic int exp_addr(input int n);
    int a;
    a = 0;
    foreach (exp_e[k]) if (exp_e[k] <= n) a = k;
    return a;
  endfunction

  task automatic play(input int rst_at, input int xstart, input bit dup);
    int last, nexp;
    build_model();
    obs_n.delete();
    obs_m.delete();
    last = (rst_at >= 0) ? rst_at + 1 : exp_done + 1;
    for (int n = 0; n <= last; n++) begin
      if (rst_at >= 0 && n == rst_at + 1) begin
        chk("rst_addr", addr, 0);
        chk("rst_spawn", spawn, 0);
        chk("rst_valid", spawn_valid, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step, 0);
      end else begin
        if (n >= 1) begin
          chk("playing", playing, n < exp_done);
          chk("done", done, n == exp_done);
          if (n <= exp_done) chk("addr", addr, exp_addr(n));
          if (n == exp_done) chk("step", step, exp_step);
        end
        if (spawn_valid === 1'b1) begin
          obs_n.push_back(n);
          obs_m.push_back(spawn);
        end else begin
          chk("spawn_idle", spawn, 0);
        end
      end
      if (n == last) break;
      start = (n == 0) || (n == xstart) || (dup && n == exp_done);
      pause = pz[n];
      rst   = (n == rst_at);
      @(negedge clk);
    end
    nexp = 0;
    foreach (exp_sp_n[i])
      if (rst_at < 0 || exp_sp_n[i] <= rst_at) nexp++;
    chk("spawn_count", obs_n.size(), nexp);
    for (int i = 0; i < nexp && i < obs_n.size(); i++) begin
      chk("spawn_time", obs_n[i], exp_sp_n[i]);
      chk("spawn_mask", obs_m[i], exp_sp_m[i]);
    end
  endtask

  task automatic idle(input int k);
    start = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < k; i++) begin
      pause = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    pause = 1'b0;
  endtask

  task automatic clear_chart();
    for (int k = 0; k < 64; k++) rom[k] = 4'hF;
    for (int n = 0; n < NP; n++) pz[n] = 1'b0;
  endtask

  initial begin
    int len;
    vecs  = 0;
    errs  = 0;
    rst   = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    clear_chart();
    repeat (3) @(negedge clk);
    chk("reset_addr", addr, 0);
    chk("reset_spawn", spawn, 0);
    chk("reset_valid", spawn_valid, 0);
    chk("reset_playing", playing, 0);
    chk("reset_done", done, 0);
    chk("reset_step", step, 0);
    rst = 1'b0;
    idle(2);

    // basic play
    clear_chart();
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    play(-1, -1, 1'b0);
    idle(3);

    // rest step
    clear_chart();
    rom[0] = 4'b1000;
    rom[1] = 4'b0000;
    rom[2] = 4'b0010;
    play(-1, -1, 1'b0);
    idle(3);

    // pause in first WAIT, pause in FETCH/EMIT of the next step
    clear_chart();
    rom[0] = 4'b0001;
    rom[1] = 4'b0001;
    for (int n = 3; n < 8; n++) pz[n] = 1'b1;
    pz[14] = 1'b1;
    pz[15] = 1'b1;
    play(-1, -1, 1'b0);
    idle(3);

    // exhaustion without END
    clear_chart();
    for (int k = 0; k < 64; k++) rom[k] = 4'b0001;
    play(-1, -1, 1'b0);
    idle(3);

    // reset in the WAIT after the third spawn, then replay
    clear_chart();
    for (int k = 0; k < 10; k++) rom[k] = 4'(1 << (k % 4));
    play(21, -1, 1'b0);
    play(-1, -1, 1'b0);
    idle(2);

    // start while playing, start with done, restart next cycle
    clear_chart();
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    play(-1, 5, 1'b1);
    play(-1, 12, 1'b0);
    idle(2);

    // random charts and pauses
    for (int r = 0; r < 8; r++) begin
      clear_chart();
      len = $urandom_range(1, 20);
      for (int k = 0; k < len; k++) rom[k] = 4'($urandom_range(0, 14));
      for (int n = 0; n < NP; n++) pz[n] = ($urandom_range(0, 3) == 0);
      play(-1, -1, 1'(r % 2));
      idle($urandom_range(0, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
